toaplan2_prog_buffer: RTL

Write buffer between the ROM download byte stream and the SDRAM controller's programming port. It coalesces consecutive even/odd byte writes to the same word into a single full-word write and queues entries in a small FIFO. It then drives the PROG_WE / PROG_RDY handshake one entry at a time, so a slow SDRAM acknowledge never drops download bytes. It sits downstream of the per-byte address/bank mapping logic and upstream of the SDRAM controller.

---
 rtl/toaplan2_prog_pkg.sv | 23 ++
 rtl/toaplan2_prog_fifo.sv | 46 ++++
 rtl/toaplan2_prog_buffer.sv | 119 +++++++++++
 3 files changed

// File: rtl/toaplan2_prog_pkg.sv
// toaplan2_prog_pkg: shared entry layout, byte-mask constants and write FSM encodings
package toaplan2_prog_pkg;
    localparam int MASK_W   = 2;
    localparam int MASK_OFF = 0;
    localparam int DATA_W   = 16;
    localparam int DATA_OFF = MASK_OFF + MASK_W;
    localparam int BA_W     = 2;
    localparam int BA_OFF   = DATA_OFF + DATA_W;
    localparam int ADDR_OFF = BA_OFF + BA_W;

    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b00;
    localparam logic [1:0] MASK_NONE = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    function automatic int entry_w(input int aw);
        return ADDR_OFF + aw;
    endfunction
endpackage

// File: rtl/toaplan2_prog_fifo.sv
// toaplan2_prog_fifo: shift-register FIFO whose slot 0 is the registered head
module toaplan2_prog_fifo #(
    parameter int            DEPTH   = 4,
    parameter int            W       = 24,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_cnt;
    logic          w_rd;
    logic          w_wr;
    logic [CW-1:0] w_wi;

    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_head  = r_mem[0];
    assign w_rd    = i_pop & ~o_empty;
    assign w_wr    = i_push & (~o_full | w_rd);
    assign w_wi    = r_cnt - CW'(w_rd);

    // shift down on pop; a write lands in the first free slot after the shift
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= RST_VAL;
        end else begin
            r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
            if (w_rd) begin
                for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
                r_mem[DEPTH-1] <= RST_VAL;
            end
            if (w_wr) r_mem[w_wi[PW-1:0]] <= i_din;
        end
    end
endmodule

// File: rtl/toaplan2_prog_buffer.sv
// toaplan2_prog_buffer: coalesces download bytes into words and feeds the SDRAM programming port
module toaplan2_prog_buffer
    import toaplan2_prog_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 22
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          DOWNLOADING,
    input  logic          IN_WE,
    input  logic [AW-1:0] IN_ADDR,
    input  logic [1:0]    IN_BA,
    input  logic [7:0]    IN_DATA,
    input  logic [1:0]    IN_MASK,
    output logic [AW-1:0] PROG_ADDR,
    output logic [1:0]    PROG_BA,
    output logic [15:0]   PROG_DATA,
    output logic [1:0]    PROG_MASK,
    output logic          PROG_WE,
    input  logic          PROG_RDY,
    output logic          DWNLD_BUSY,
    output logic          OVERFLOW
);
    localparam int EW = entry_w(AW);

    logic [AW-1:0] r_hr_addr;
    logic [1:0]    r_hr_ba;
    logic [15:0]   r_hr_data;
    logic [1:0]    r_hr_mask;
    logic          r_hr_vld;
    logic          r_dl_d;
    logic          r_ovf;
    logic [1:0]    r_st;

    logic          w_legal;
    logic          w_in;
    logic          w_match;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;
    logic          w_rise;
    logic [15:0]   w_merged;
    logic [EW-1:0] w_push_ent;
    logic [EW-1:0] w_head;

    assign w_legal    = IN_MASK == MASK_LO || IN_MASK == MASK_HI;
    assign w_in       = IN_WE & w_legal;
    assign w_match    = r_hr_vld && IN_ADDR == r_hr_addr && IN_BA == r_hr_ba && IN_MASK == ~r_hr_mask;
    assign w_merged   = IN_MASK == MASK_HI ? {IN_DATA, r_hr_data[7:0]} : {r_hr_data[15:8], IN_DATA};
    assign w_push     = r_hr_vld & (w_in | ~DOWNLOADING);
    assign w_push_ent = (w_in & w_match) ? {IN_ADDR, IN_BA, w_merged, MASK_WORD}
                                         : {r_hr_addr, r_hr_ba, r_hr_data, r_hr_mask};
    assign w_pop      = (r_st == ST_WRITE) & PROG_RDY;
    assign w_drop     = w_push & w_full & ~w_pop;
    assign w_rise     = DOWNLOADING & ~r_dl_d;

    assign PROG_ADDR  = w_head[ADDR_OFF +: AW];
    assign PROG_BA    = w_head[BA_OFF +: BA_W];
    assign PROG_DATA  = w_head[DATA_OFF +: DATA_W];
    assign PROG_MASK  = w_head[MASK_OFF +: MASK_W];
    assign PROG_WE    = r_st == ST_WRITE;
    assign DWNLD_BUSY = DOWNLOADING | r_hr_vld | ~w_empty | PROG_WE;
    assign OVERFLOW   = r_ovf;

    toaplan2_prog_fifo #(
        .DEPTH   (DEPTH),
        .W       (EW),
        .RST_VAL (EW'(MASK_NONE))
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_push  (w_push),
        .i_din   (w_push_ent),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // hold register: keeps a lone byte until its partner arrives, a mismatch evicts it, or a flush
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hr_vld  <= 1'b0;
            r_hr_addr <= '0;
            r_hr_ba   <= '0;
            r_hr_data <= '0;
            r_hr_mask <= MASK_NONE;
        end else if (w_in) begin
            r_hr_vld  <= ~w_match;
            r_hr_addr <= IN_ADDR;
            r_hr_ba   <= IN_BA;
            r_hr_data <= {IN_DATA, IN_DATA};
            r_hr_mask <= IN_MASK;
        end else if (!DOWNLOADING) begin
            r_hr_vld  <= 1'b0;
        end
    end

    // write handshake: one entry per WRITE, then a mandatory single GAP cycle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_st <= ST_IDLE;
        else r_st <= r_st == ST_IDLE  ? (w_empty ? ST_IDLE : ST_WRITE) :
                     r_st == ST_WRITE ? (PROG_RDY ? ST_GAP : ST_WRITE) : ST_IDLE;
    end

    // sticky overflow for dropped bytes, cleared when a new download begins
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dl_d <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_dl_d <= DOWNLOADING;
            r_ovf  <= w_drop | (IN_WE & ~w_legal) | (r_ovf & ~w_rise);
        end
    end
endmodule
